piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in serial-out transmitter: captures a DW-bit word on a load handshake, then shifts it out one bit per enabled clock.
- Serves as the transmit end for the team's parallel register datapath and feeds serial links/pins from registered words.
- Provides ready/busy/done status so an upstream controller can stream words without a FIFO.

Parameters:
- DW, 4, data word width in bits (DW >= 1).
- MSB_FIRST, 1, 1 = transmit D_i[DW-1] first; 0 = transmit D_i[0] first.

Ports:
- clk_50MHz_i  input  1  system clock, rising-edge active.
- rst_async_la_i  input  1  reset, asynchronous, active-low.
- D_i  input  DW  parallel word to transmit.
- Load_i  input  1  load request; accepted only when Ready_o=1.
- Enable_i  input  1  bit-advance strobe (baud tick); sampled each clock in SHIFT.
- Ready_o  output  1  high in IDLE: a Load_i is accepted this cycle.
- Busy_o  output  1  high while a word is being transmitted (SHIFT).
- Serial_o  output  1  serial data out, registered.
- Done_o  output  1  one-cycle registered pulse after the last bit completes.

Behaviour:
- Reset (async, rst_async_la_i=0): state=IDLE, shift reg=0, bit counter=0, Serial_o=0, Busy_o=0, Done_o=0, Ready_o=1. Reset mid-frame aborts immediately with no Done_o pulse.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Bit counter width is ceil(log2(DW+1)).
- IDLE:
  - Serial_o=0 (idle level), Ready_o=1, Busy_o=0.
  - On an edge with Load_i=1: capture D_i, counter<=0, Serial_o<=first bit (D_i[DW-1] if MSB_FIRST else D_i[0]), state<=SHIFT.
  - Latency: the first bit appears on Serial_o the cycle after the load edge.
- SHIFT:
  - Ready_o=0, Busy_o=1. Load_i is ignored and D_i changes have no effect.
  - On an edge with Enable_i=0: Serial_o, counter and shift reg hold.
  - On an edge with Enable_i=1 and counter<DW-1: shift the register one position toward the output end, Serial_o<=next bit, counter<=counter+1.
  - On an edge with Enable_i=1 and counter==DW-1: state<=IDLE, Serial_o<=0, Done_o<=1 for exactly one cycle.
- With Enable_i held high, each bit occupies exactly one clock, so a frame is DW cycles of Busy_o.
- Back-to-back frames: Ready_o is high in the cycle Done_o is high. A Load_i in that cycle starts the next frame, giving a minimum 1-cycle idle gap (Serial_o=0) between frames.
- DW=1: the single bit is presented after the load. The first Enable_i edge ends the frame and pulses Done_o.
- Load_i and Enable_i together in IDLE: Load_i wins. Enable_i has no effect in IDLE.
- Done_o is cleared on the following edge regardless of inputs.

Test Plan:
- Reset values: assert reset mid-SHIFT (DW=4, after 2 bits) -> same cycle Serial_o=0, Busy_o=0, Ready_o=1, Done_o=0. After release, no Done_o pulse.
- MSB_FIRST=1, DW=4: load 4'b1011 with Enable_i=1 continuous -> Serial_o=1,0,1,1 on cycles 1-4 after the load edge. Busy_o high cycles 1-4. Done_o high cycle 5 only. Serial_o=0 at cycle 5.
- MSB_FIRST=0, DW=8: load 8'hA5 with Enable_i=1 -> Serial_o sequence 1,0,1,0,0,1,0,1. Done_o after 8 bits.
- Enable_i gating: DW=4, load 4'b1100, Enable_i pulsed every 3rd cycle -> each bit held 3 cycles. Done_o 1 cycle after the 4th enabled edge. Total Busy_o = 12 cycles.
- Load during busy: DW=4, load 4'b1111, then Load_i=1 with D_i=4'b0000 every SHIFT cycle -> output stays 1,1,1,1 (no corruption). Load_i held into the Done_o cycle -> second frame 0,0,0,0 starts after a 1-cycle idle gap.
- DW=1: load 1'b1 with Enable_i=1 -> Serial_o=1 for one cycle. Done_o pulses the next cycle.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: captures a DW-bit word on Load_i while idle,
// then presents one bit per enabled clock on a registered Serial_o.
module piso_serializer #(
  parameter int unsigned DW        = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic          clk_50MHz_i,
  input  logic          rst_async_la_i,
  input  logic [DW-1:0] D_i,
  input  logic          Load_i,
  input  logic          Enable_i,
  output logic          Ready_o,
  output logic          Busy_o,
  output logic          Serial_o,
  output logic          Done_o,
  output logic          o_dbg_state
);

  localparam int unsigned      CW   = $clog2(DW + 1);
  localparam logic [CW-1:0]    LAST = CW'(DW - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_shift;
  logic [CW-1:0]   r_cnt;
  logic            r_serial;
  logic            r_done;

  logic [DW-1:0]   w_shift_next;
  logic            w_next_bit;
  logic            w_first_bit;
  logic            w_last;

  // Handshake: a word is taken on any rising edge where Ready_o=1 and Load_i=1;
  // Ready_o depends only on the state register, so the upstream may hold Load_i.
  assign w_shift_next = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  assign w_next_bit   = MSB_FIRST ? w_shift_next[DW-1] : w_shift_next[0];
  assign w_first_bit  = MSB_FIRST ? D_i[DW-1] : D_i[0];
  assign w_last       = (r_cnt == LAST);

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_serial <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Load_i) begin
            r_shift  <= D_i;
            r_cnt    <= '0;
            r_serial <= w_first_bit;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (Enable_i) begin
            if (w_last) begin
              r_state  <= ST_IDLE;
              r_serial <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_shift  <= w_shift_next;
              r_serial <= w_next_bit;
              r_cnt    <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_serial <= 1'b0;
        end
      endcase
    end
  end

  assign Ready_o     = (r_state == ST_IDLE);
  assign Busy_o      = (r_state == ST_SHIFT);
  assign Serial_o    = r_serial;
  assign Done_o      = r_done;
  assign o_dbg_state = r_state;

`ifndef SYNTHESIS
  a_ready_xor_busy: assert property (@(posedge clk_50MHz_i) disable iff (!rst_async_la_i)
    Ready_o != Busy_o);
  a_done_one_cycle: assert property (@(posedge clk_50MHz_i) disable iff (!rst_async_la_i)
    Done_o |=> !Done_o);
  a_done_when_idle: assert property (@(posedge clk_50MHz_i) disable iff (!rst_async_la_i)
    Done_o |-> Ready_o);
  a_cnt_in_range: assert property (@(posedge clk_50MHz_i) disable iff (!rst_async_la_i)
    r_cnt <= LAST);
`endif

endmodule
